// File: rtl/risc16_pkg.sv
// -----------------------------------------------------------------------------
// risc16_pkg
// Shared definitions for the RISC-16 ALU sequencing logic.
//   - DATA_W / REG_AW / OP_W : datapath, register-address and opcode widths
//   - OP_*                   : ALU opcode encodings (0x0 NOP .. 0xB DEC)
//   - alu_seq_state_t        : sequencer FSM state encoding
//   - is_alu_op / is_illegal_op : opcode classification helpers
// -----------------------------------------------------------------------------
package risc16_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 4;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_NOP = 4'h0;
   localparam logic [OP_W-1:0] OP_ADD = 4'h1;
   localparam logic [OP_W-1:0] OP_SUB = 4'h2;
   localparam logic [OP_W-1:0] OP_MUL = 4'h3;
   localparam logic [OP_W-1:0] OP_AND = 4'h4;
   localparam logic [OP_W-1:0] OP_OR  = 4'h5;
   localparam logic [OP_W-1:0] OP_XOR = 4'h6;
   localparam logic [OP_W-1:0] OP_NOT = 4'h7;
   localparam logic [OP_W-1:0] OP_SHL = 4'h8;
   localparam logic [OP_W-1:0] OP_SHR = 4'h9;
   localparam logic [OP_W-1:0] OP_INC = 4'hA;
   localparam logic [OP_W-1:0] OP_DEC = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPND = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } alu_seq_state_t;

   // Opcodes that run through OPND/EXEC/WB.
   function automatic logic is_alu_op(input logic [OP_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_DEC);
   endfunction

   // Opcodes above DEC are accepted but only raise the illegal pulse.
   function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
      return op > OP_DEC;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
// Instruction handshake between decode (master) and the ALU sequencer (slave).
//   instr_valid  : decode offers an instruction
//   instr_ready  : sequencer can accept this cycle
//   instr_opcode : ALU opcode
//   instr_rx     : source A / destination register
//   instr_ry     : source B register
// -----------------------------------------------------------------------------
interface alu_sequencer_if;
   import risc16_pkg::*;

   logic              instr_valid;
   logic              instr_ready;
   logic [OP_W-1:0]   instr_opcode;
   logic [REG_AW-1:0] instr_rx;
   logic [REG_AW-1:0] instr_ry;

   modport master (
      output instr_valid,
      output instr_opcode,
      output instr_rx,
      output instr_ry,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_opcode,
      input  instr_rx,
      input  instr_ry,
      output instr_ready
   );

endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller placed between instruction decode, the RISC-16 ALU
// and the register file. One instruction at a time: IDLE -> OPND -> EXEC -> WB.
// MUL stays in EXEC for MUL_CYCLES cycles, every other op for one.
//
// Parameters
//   MUL_CYCLES   : EXEC cycles for MUL (>= 1)
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   instr_if     : instruction handshake (slave side)
//   rf_raddr_a/b : register file read addresses (rf_rdata_a/b combinational)
//   alu_*_value  : ALU operands, alu_opcode ALU op (NOP outside EXEC)
//   alu_out/carry/zero/parity : ALU result and flags
//   rf_we/waddr/wdata : register file writeback, one cycle in WB
//   flag_*       : architectural flags, updated on the edge leaving WB
//   busy         : FSM not in IDLE
//   illegal      : one-cycle pulse after accepting opcode 0xC..0xF
// -----------------------------------------------------------------------------
module alu_sequencer
   import risc16_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   alu_sequencer_if.slave    instr_if,
   output logic [REG_AW-1:0] rf_raddr_a,
   output logic [REG_AW-1:0] rf_raddr_b,
   input  logic [DATA_W-1:0] rf_rdata_a,
   input  logic [DATA_W-1:0] rf_rdata_b,
   output logic [DATA_W-1:0] alu_rx_value,
   output logic [DATA_W-1:0] alu_ry_value,
   output logic [OP_W-1:0]   alu_opcode,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   input  logic              alu_zero,
   input  logic              alu_parity,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              flag_carry,
   output logic              flag_zero,
   output logic              flag_parity,
   output logic              busy,
   output logic              illegal
);

   // Counter only needs to hold MUL_CYCLES-1.
   localparam int unsigned    CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

   alu_seq_state_t    r_state;
   alu_seq_state_t    w_state_nxt;
   logic              w_accept;
   logic              w_accept_alu;
   logic              w_exec_done;

   logic [OP_W-1:0]   r_opcode;
   logic [REG_AW-1:0] r_rx;
   logic [REG_AW-1:0] r_ry;
   logic [DATA_W-1:0] r_opa;
   logic [DATA_W-1:0] r_opb;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_result;
   logic              r_res_carry;
   logic              r_res_zero;
   logic              r_res_parity;
   logic              r_flag_carry;
   logic              r_flag_zero;
   logic              r_flag_parity;
   logic              r_illegal;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every flop in the
   // design samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and control strobes
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_accept_alu = 1'b0;
      w_exec_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // rst needs no gating here: reset has priority in every flop.
            if (instr_if.instr_valid) begin
               w_accept = 1'b1;
               if (is_alu_op(instr_if.instr_opcode)) begin
                  w_accept_alu = 1'b1;
                  w_state_nxt  = ST_OPND;
               end
            end
         end
         ST_OPND: w_state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (r_cnt == '0) begin
               w_exec_done = 1'b1;
               w_state_nxt = ST_WB;
            end
         end
         ST_WB:   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: datapath registers are reset too, because every output they drive
   // must read 0 after reset, not just the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode      <= OP_NOP;
         r_rx          <= '0;
         r_ry          <= '0;
         r_opa         <= '0;
         r_opb         <= '0;
         r_cnt         <= '0;
         r_result      <= '0;
         r_res_carry   <= 1'b0;
         r_res_zero    <= 1'b0;
         r_res_parity  <= 1'b0;
         r_flag_carry  <= 1'b0;
         r_flag_zero   <= 1'b0;
         r_flag_parity <= 1'b0;
         r_illegal     <= 1'b0;
      end else begin
         r_illegal <= w_accept && is_illegal_op(instr_if.instr_opcode);

         // NOP/illegal are discarded, so the read addresses keep their value.
         if (w_accept_alu) begin
            r_opcode <= instr_if.instr_opcode;
            r_rx     <= instr_if.instr_rx;
            r_ry     <= instr_if.instr_ry;
         end

         // Operands are read here, before WB, so rx == ry needs no bypass.
         if (r_state == ST_OPND) begin
            r_opa <= rf_rdata_a;
            r_opb <= rf_rdata_b;
            r_cnt <= (r_opcode == OP_MUL) ? MUL_LAST : '0;
         end else if ((r_state == ST_EXEC) && !w_exec_done) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end

         if (w_exec_done) begin
            r_result     <= alu_out;
            r_res_carry  <= alu_carry;
            r_res_zero   <= alu_zero;
            r_res_parity <= alu_parity;
         end

         if (r_state == ST_WB) begin
            r_flag_carry  <= r_res_carry;
            r_flag_zero   <= r_res_zero;
            r_flag_parity <= r_res_parity;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign instr_if.instr_ready = (r_state == ST_IDLE) && !rst;
   assign busy                 = (r_state != ST_IDLE);
   assign illegal              = r_illegal;

   assign rf_raddr_a   = r_rx;
   assign rf_raddr_b   = r_ry;
   assign alu_rx_value = r_opa;
   assign alu_ry_value = r_opb;
   // NOP outside EXEC keeps the ALU output at 0.
   assign alu_opcode   = (r_state == ST_EXEC) ? r_opcode : OP_NOP;

   // A reset landing in WB aborts the write: the RF samples on the same edge.
   assign rf_we    = (r_state == ST_WB) && !rst;
   assign rf_waddr = (r_state == ST_WB) ? r_rx     : '0;
   assign rf_wdata = (r_state == ST_WB) ? r_result : '0;

   assign flag_carry  = r_flag_carry;
   assign flag_zero   = r_flag_zero;
   assign flag_parity = r_flag_parity;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the RISC-16 ALU between instruction decode and the register file. It accepts one ALU instruction at a time over a valid/ready handshake, reads operands Rx/Ry, drives the ALU, and stretches MUL over a configurable number of cycles. It writes the result back to Rx and holds the architectural carry/zero/parity flags.

## Interface
- `MUL_CYCLES`, default 3: EXEC cycles spent on opcode 0x3 (MUL). Legal range is ≥1. All other ops take 1 EXEC cycle.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: sequencer can accept.
- `instr_opcode` in 4: ALU opcode, encoded 0x1 ADD … 0xB DEC.
- `instr_rx` in 4: source A and destination register.
- `instr_ry` in 4: source B register.
- `rf_raddr_a`, `rf_raddr_b` out 4: register file read addresses.
- `rf_rdata_a`, `rf_rdata_b` in 16: combinational read data.
- `alu_rx_value`, `alu_ry_value` out 16: ALU operands.
- `alu_opcode` out 4: ALU opcode.
- `alu_out` in 16; `alu_carry`, `alu_zero`, `alu_parity` in 1: ALU result and flags.
- `rf_we` out 1; `rf_waddr` out 4; `rf_wdata` out 16: writeback port.
- `flag_carry`, `flag_zero`, `flag_parity` out 1: architectural flags.
- `busy` out 1: high in any state other than IDLE.
- `illegal` out 1: one-cycle pulse on an illegal opcode.

## Operation
- FSM states: IDLE → OPND → EXEC → WB → IDLE.
- **IDLE**
  - `instr_ready` = 1. On `instr_valid & instr_ready`, capture opcode, rx and ry.
  - Opcodes 0x1–0xB go to OPND.
  - Opcode 0x0 (NOP) is accepted and discarded; stay in IDLE.
  - Opcodes 0xC–0xF are accepted; stay in IDLE and pulse `illegal` in the next cycle. No writeback, flags unchanged.
- **OPND**
  - `rf_raddr_a` = captured rx, `rf_raddr_b` = captured ry.
  - Latch the read data into the operand registers.
  - Load the cycle counter with MUL_CYCLES−1 for MUL, else 0. Go to EXEC.
- **EXEC**
  - `alu_opcode` = captured opcode; operands come from the operand registers.
  - Counter decrements each cycle. When the counter is 0, latch `alu_out` and the three ALU flags into the result registers and go to WB.
- **WB**
  - `rf_we` = 1 for exactly one cycle, `rf_waddr` = rx, `rf_wdata` = latched result.
  - The flag outputs take the latched flags on the edge that leaves WB. Go to IDLE.
- Outside EXEC, `alu_opcode` = 0x0, so the ALU outputs 0. Operand outputs hold their last value.
- Outside WB, `rf_we` = 0. Read addresses hold their last value.
- Unary ops (0x7–0xB) still read Ry; the value is ignored by the ALU.
- rx == ry is legal: the read completes in OPND, before the write in WB.
- All datapath arithmetic is done in the ALU, modulo 2^16. The sequencer performs no arithmetic beyond the counter.
- Reset in any state: go to IDLE and abort any instruction in flight with no writeback.

## Timing
- Reset values: `instr_ready` 0 while `rst`=1, then 1 in the first cycle after reset. All other outputs are 0, including flags, `busy`, `illegal`, `rf_we` and all address/data outputs.
- Handshake: sampled at edge e0. Non-MUL ops:
  - OPND runs e0–e1, EXEC e1–e2, WB e2–e3.
  - `rf_we` is high between e2 and e3.
  - Flags are visible, and `instr_ready` is 1 again, after e3.
- MUL: EXEC lasts MUL_CYCLES cycles, so `rf_we` rises MUL_CYCLES+1 cycles after e0.
- Throughput: at most one ALU instruction per 4 cycles (3+MUL_CYCLES for MUL). NOP and illegal opcodes take 1 cycle.
- `instr_ready` is a pure decode of state==IDLE and !rst, with no combinational path from `instr_valid`.
- If `instr_valid` is held high across WB, the next instruction is accepted on the first IDLE edge.
- `illegal` is high for exactly one cycle, starting the cycle after acceptance. A new instruction may be accepted during that cycle.

## Structure
- Shared package `risc16_pkg`:
  - Opcode constants `OP_NOP`=0x0, `OP_ADD` … `OP_DEC`=0xB, `OP_MUL`=0x3.
  - State enum `alu_seq_state_t`.
  - Width constants for data (16) and register address (4).
- Single flat module with no sub-module. The ALU and register file are sibling instances wired by the parent datapath.

## Test plan
- ADD, R1=0xFFFF, R2=0x0001 → `rf_wdata`=0x0000 to R1; carry=1, zero=1, parity=1; `rf_we` high only in the cycle e2–e3.
- MUL, MUL_CYCLES=3, R5=0x0100, R6=0x0100 → `rf_wdata`=0x0000, zero=1; `rf_we` 4 cycles after handshake; `busy` high for 5 cycles.
- Opcode 0xD → `illegal` pulses for 1 cycle; no `rf_we`; flags keep their prior values; `instr_ready` high the next cycle.
- Back-to-back with `instr_valid` held: SUB R3=5, R4=7, then INC R3.
  - SUB → R3=0xFFFE, carry=1, parity=0.
  - INC → R3=0xFFFF, carry=0, parity=1.
  - Second acceptance exactly 4 cycles after the first.
- `rst` pulsed during the second EXEC cycle of a MUL → no `rf_we`, all flags 0, `instr_ready` 1 in the cycle after `rst` deasserts.
- NOP (0x0) → no `rf_we`, flags unchanged, `busy` stays 0, next instruction accepted 1 cycle later.
